// File: rtl/merc_exec_pkg.sv
// Shared definitions for the MERC execution unit: opcode encoding, FSM states
// and the rule that decides whether an op takes the iterative path.
package merc_exec_pkg;

   localparam int OP_W = 4;

   localparam logic [OP_W-1:0] OP_ADD  = 4'd0,
                               OP_SUB  = 4'd1,
                               OP_AND  = 4'd2,
                               OP_OR   = 4'd3,
                               OP_XOR  = 4'd4,
                               OP_SLL  = 4'd5,
                               OP_SRL  = 4'd6,
                               OP_SRA  = 4'd7,
                               OP_MULU = 4'd8,
                               OP_DIVU = 4'd9;

   typedef enum logic [1:0] {IDLE, ITER, FIN} state_e;

   // A divide by zero resolves in one cycle, so only a real MULU/DIVU iterates.
   function automatic logic is_iter_op(input logic [OP_W-1:0] op, input logic b_zero);
      return (op == OP_MULU) || ((op == OP_DIVU) && !b_zero);
   endfunction

endpackage

// File: rtl/merc_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) datapath.
// One step per cycle; the caller sequences load, step and watches last_o.
module merc_muldiv_iter #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic             step_i,
   input  logic             mode_i,   // 0: multiply, 1: divide
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] lo_o,
   output logic [WIDTH-1:0] hi_o,
   output logic             last_o
);

   localparam int                CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(WIDTH);

   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] opnd_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic             div_ge;

   // hi:lo is one double-width shift register; lo starts as multiplier/dividend.
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      div_shift = {hi_q, lo_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      div_ge    = div_shift >= {1'b0, opnd_q};

      hi_d  = hi_q;
      lo_d  = lo_q;
      cnt_d = cnt_q;
      if (load_i) begin
         hi_d  = '0;
         lo_d  = a_i;
         cnt_d = CNT_INIT;
      end else if (step_i) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (mode_i) begin
            hi_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], div_ge};
         end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
         end
      end
   end

   // NOTE: every datapath register is reset too, so no X can reach the outputs
   // after an aborted operation; the cost is negligible at this size.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hi_q   <= '0;
         lo_q   <= '0;
         opnd_q <= '0;
         cnt_q  <= '0;
      end else begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         cnt_q <= cnt_d;
         if (load_i) opnd_q <= b_i;
      end
   end

   assign lo_o   = lo_q;
   assign hi_o   = hi_q;
   assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/merc_exec_unit.sv
// MERC execution unit: single-cycle ALU/shifter plus iterative MULU/DIVU,
// with registered result and comparison flags updated on each Done pulse.
module merc_exec_unit
   import merc_exec_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [OP_W-1:0]  op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic [WIDTH-1:0] result_hi_o,
   output logic             eq_o,
   output logic             gr_o,
   output logic             lt_o,
   output logic             zero_o,
   output logic             ovfl_o,
   output logic             div_by_zero_o
);

   state_e state_q, state_d;

   logic             done_q, done_d;
   logic [WIDTH-1:0] result_q, result_hi_q;
   logic             eq_q, gr_q, lt_q, zero_q, ovfl_q, dbz_q;
   logic [OP_W-1:0]  op_q;
   logic [2:0]       cmp_q;

   logic             load, step, out_we, sel_iter;
   logic [WIDTH-1:0] md_lo, md_hi;
   logic             md_last;

   logic [WIDTH-1:0] add_res, sub_res;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0] alu_lo, alu_hi;
   logic             alu_ovfl, alu_dbz;
   logic             eq_live, gr_live, lt_live;

   logic [WIDTH-1:0] res_d, res_hi_d;
   logic             ovfl_d, dbz_d;
   logic [2:0]       cmp_d;

   assign add_res = a_i + b_i;
   assign sub_res = a_i - b_i;
   assign shamt   = b_i[SHAMT_W-1:0];
   assign eq_live = (a_i == b_i);
   assign gr_live = ($signed(a_i) > $signed(b_i));
   assign lt_live = ($signed(a_i) < $signed(b_i));

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      alu_lo   = '0;
      alu_hi   = '0;
      alu_ovfl = 1'b0;
      alu_dbz  = 1'b0;
      case (op_i)
         OP_ADD: begin
            alu_lo   = add_res;
            alu_ovfl = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (add_res[WIDTH-1] != a_i[WIDTH-1]);
         end
         OP_SUB: begin
            alu_lo   = sub_res;
            alu_ovfl = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (sub_res[WIDTH-1] != a_i[WIDTH-1]);
         end
         OP_AND:  alu_lo = a_i & b_i;
         OP_OR:   alu_lo = a_i | b_i;
         OP_XOR:  alu_lo = a_i ^ b_i;
         OP_SLL:  alu_lo = a_i << shamt;
         OP_SRL:  alu_lo = a_i >> shamt;
         OP_SRA:  alu_lo = $signed(a_i) >>> shamt;
         OP_DIVU: begin
            // Only reached as a single-cycle op when B is zero.
            alu_lo  = '1;
            alu_hi  = a_i;
            alu_dbz = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      done_d   = 1'b0;
      load     = 1'b0;
      step     = 1'b0;
      out_we   = 1'b0;
      sel_iter = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (is_iter_op(op_i, b_i == '0)) begin
                  load    = 1'b1;
                  state_d = ITER;
               end else begin
                  out_we = 1'b1;
                  done_d = 1'b1;
               end
            end
         end
         ITER: begin
            step = 1'b1;
            if (md_last) state_d = FIN;
         end
         FIN: begin
            out_we   = 1'b1;
            done_d   = 1'b1;
            sel_iter = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      res_d    = sel_iter ? md_lo : alu_lo;
      res_hi_d = sel_iter ? md_hi : alu_hi;
      ovfl_d   = sel_iter ? ((op_q == OP_MULU) && (md_hi != '0)) : alu_ovfl;
      dbz_d    = sel_iter ? 1'b0 : alu_dbz;
      cmp_d    = sel_iter ? cmp_q : {eq_live, gr_live, lt_live};
   end

   merc_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .load_i (load),
      .step_i (step),
      .mode_i (op_q == OP_DIVU),
      .a_i    (a_i),
      .b_i    (b_i),
      .lo_o   (md_lo),
      .hi_o   (md_hi),
      .last_o (md_last)
   );

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         done_q      <= 1'b0;
         op_q        <= '0;
         cmp_q       <= '0;
         result_q    <= '0;
         result_hi_q <= '0;
         eq_q        <= 1'b0;
         gr_q        <= 1'b0;
         lt_q        <= 1'b0;
         zero_q      <= 1'b0;
         ovfl_q      <= 1'b0;
         dbz_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         if (load) begin
            op_q  <= op_i;
            cmp_q <= {eq_live, gr_live, lt_live};
         end
         if (out_we) begin
            result_q           <= res_d;
            result_hi_q        <= res_hi_d;
            {eq_q, gr_q, lt_q} <= cmp_d;
            zero_q             <= (res_d == '0);
            ovfl_q             <= ovfl_d;
            dbz_q              <= dbz_d;
         end
      end
   end

   assign busy_o        = (state_q != IDLE);
   assign done_o        = done_q;
   assign result_o      = result_q;
   assign result_hi_o   = result_hi_q;
   assign eq_o          = eq_q;
   assign gr_o          = gr_q;
   assign lt_o          = lt_q;
   assign zero_o        = zero_q;
   assign ovfl_o        = ovfl_q;
   assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_merc_exec_unit.sv
// Self-checking bench for merc_exec_unit: 16-bit and 32-bit instances against
// an arithmetic reference model; directed cases plus randomized operations.
module tb_merc_exec_unit;
   import merc_exec_pkg::*;

   typedef struct packed {
      logic [63:0] lo;
      logic [63:0] hi;
      logic        eq, gr, lt, zero, ovfl, dbz;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start16 = 1'b0, start32 = 1'b0;
   logic [3:0]  op = '0;
   logic [31:0] a = '0, b = '0;

   logic        d16_busy, d16_done, d16_eq, d16_gr, d16_lt, d16_zero, d16_ovfl, d16_dbz;
   logic [15:0] d16_res, d16_hi;
   logic        d32_busy, d32_done, d32_eq, d32_gr, d32_lt, d32_zero, d32_ovfl, d32_dbz;
   logic [31:0] d32_res, d32_hi;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   merc_exec_unit #(.WIDTH(16)) dut16 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start16), .op_i(op),
      .a_i(a[15:0]), .b_i(b[15:0]), .busy_o(d16_busy), .done_o(d16_done),
      .result_o(d16_res), .result_hi_o(d16_hi), .eq_o(d16_eq), .gr_o(d16_gr),
      .lt_o(d16_lt), .zero_o(d16_zero), .ovfl_o(d16_ovfl), .div_by_zero_o(d16_dbz)
   );

   merc_exec_unit #(.WIDTH(32)) dut32 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start32), .op_i(op),
      .a_i(a), .b_i(b), .busy_o(d32_busy), .done_o(d32_done),
      .result_o(d32_res), .result_hi_o(d32_hi), .eq_o(d32_eq), .gr_o(d32_gr),
      .lt_o(d32_lt), .zero_o(d32_zero), .ovfl_o(d32_ovfl), .div_by_zero_o(d32_dbz)
   );

   // ---------------- reference model ----------------
   function automatic logic [63:0] wmask(int w);
      return (64'd1 << w) - 64'd1;
   endfunction

   function automatic longint sx(int w, logic [63:0] x);
      logic [63:0] m;
      m = wmask(w);
      if (x[w-1]) return longint'(x | ~m);
      return longint'(x & m);
   endfunction

   function automatic exp_t model(int w, logic [3:0] o, logic [63:0] av, logic [63:0] bv);
      exp_t         e;
      logic [63:0]  m;
      longint       sa, sb, s;
      int           sh;
      logic [127:0] p;
      m  = wmask(w);
      av = av & m;
      bv = bv & m;
      sa = sx(w, av);
      sb = sx(w, bv);
      sh = int'(bv % 64'(w));
      e  = '0;
      case (o)
         4'd0: begin e.lo = (av + bv) & m; s = sa + sb; e.ovfl = (s != sx(w, e.lo)); end
         4'd1: begin e.lo = (av - bv) & m; s = sa - sb; e.ovfl = (s != sx(w, e.lo)); end
         4'd2: e.lo = av & bv;
         4'd3: e.lo = av | bv;
         4'd4: e.lo = av ^ bv;
         4'd5: e.lo = (av << sh) & m;
         4'd6: e.lo = av >> sh;
         4'd7: e.lo = 64'(sa >>> sh) & m;
         4'd8: begin
            p      = {64'd0, av} * {64'd0, bv};
            e.lo   = p[63:0] & m;
            e.hi   = 64'(p >> w) & m;
            e.ovfl = (e.hi != 0);
         end
         4'd9: begin
            if (bv == 0) begin e.lo = m; e.hi = av; e.dbz = 1'b1; end
            else begin e.lo = av / bv; e.hi = av % bv; end
         end
         default: ;
      endcase
      e.eq   = (sa == sb);
      e.gr   = (sa > sb);
      e.lt   = (sa < sb);
      e.zero = (e.lo == 0);
      return e;
   endfunction

   function automatic int exp_lat(int w, logic [3:0] o, logic [63:0] bv);
      if (o == 4'd8 || (o == 4'd9 && (bv & wmask(w)) != 0)) return w + 1;
      return 0;
   endfunction

   // ---------------- DUT observation / stimulus ----------------
   function automatic exp_t obs(int w);
      exp_t e;
      if (w == 16) e = {48'd0, d16_res, 48'd0, d16_hi, d16_eq, d16_gr, d16_lt, d16_zero, d16_ovfl, d16_dbz};
      else         e = {32'd0, d32_res, 32'd0, d32_hi, d32_eq, d32_gr, d32_lt, d32_zero, d32_ovfl, d32_dbz};
      return e;
   endfunction

   function automatic logic done_w(int w);
      return (w == 16) ? d16_done : d32_done;
   endfunction

   function automatic logic busy_w(int w);
      return (w == 16) ? d16_busy : d32_busy;
   endfunction

   // Issues one op, then waits (bounded) for Done. lat counts edges after the
   // accepting edge; busy_n counts Busy samples taken before Done.
   task automatic issue(input int w, input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                        output int lat, output int busy_n);
      @(negedge clk);
      op = o; a = av; b = bv;
      if (w == 16) start16 = 1'b1; else start32 = 1'b1;
      @(posedge clk);
      lat = 0;
      busy_n = 0;
      forever begin
         @(negedge clk);
         start16 = 1'b0;
         start32 = 1'b0;
         if (done_w(w)) break;
         busy_n += int'(busy_w(w));
         @(posedge clk);
         lat++;
         if (lat > 200) begin
            vectors++; miscompares++;
            $display("FAIL done_timeout w=%0d op=%0d: no Done within %0d cycles", w, o, lat);
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      vectors++;
      if ({d16_busy, d16_done, d32_busy, d32_done} !== 4'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b want 0000", {d16_busy, d16_done, d32_busy, d32_done});
      end
      vectors++;
      if (obs(16) !== exp_t'(0) || obs(32) !== exp_t'(0)) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h / %h want 0", obs(16), obs(32));
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add_ovfl();
      int lat, busy_n;
      exp_t e;
      issue(16, OP_ADD, 32'h7FFF, 32'h0001, lat, busy_n);
      e = model(16, OP_ADD, 64'h7FFF, 64'h0001);
      vectors++;
      if (obs(16) !== e || d16_res !== 16'h8000) begin
         miscompares++;
         $display("FAIL add_ovfl: got %h want %h", obs(16), e);
      end
      vectors++;
      if (lat !== 0 || busy_n !== 0 || d16_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL add_timing: lat %0d busy %0d want 0 0", lat, busy_n);
      end
   endtask

   task automatic test_mulu_divu();
      int lat, busy_n;
      exp_t e;
      issue(16, OP_MULU, 32'h1234, 32'h0100, lat, busy_n);
      e = model(16, OP_MULU, 64'h1234, 64'h0100);
      vectors++;
      if (obs(16) !== e || d16_res !== 16'h3400 || d16_hi !== 16'h0012 || d16_ovfl !== 1'b1) begin
         miscompares++;
         $display("FAIL mulu_basic: got %h want %h", obs(16), e);
      end
      vectors++;
      if (lat !== 17 || busy_n !== 17) begin
         miscompares++;
         $display("FAIL mulu_latency: lat %0d busy %0d want 17 17", lat, busy_n);
      end
      issue(16, OP_DIVU, 32'd100, 32'd7, lat, busy_n);
      e = model(16, OP_DIVU, 64'd100, 64'd7);
      vectors++;
      if (obs(16) !== e || d16_res !== 16'd14 || d16_hi !== 16'd2 || lat !== 17) begin
         miscompares++;
         $display("FAIL divu_basic: got %h lat %0d want %h lat 17", obs(16), lat, e);
      end
      issue(16, OP_DIVU, 32'd100, 32'd0, lat, busy_n);
      e = model(16, OP_DIVU, 64'd100, 64'd0);
      vectors++;
      if (obs(16) !== e || d16_res !== 16'hFFFF || d16_hi !== 16'd100 || d16_dbz !== 1'b1 || lat !== 0) begin
         miscompares++;
         $display("FAIL divu_by_zero: got %h lat %0d want %h lat 0", obs(16), lat, e);
      end
   endtask

   task automatic test_back_to_back();
      int   cyc;
      exp_t e;
      @(negedge clk);
      op = OP_MULU; a = 32'h1234; b = 32'h0100; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      repeat (3) @(negedge clk);
      op = OP_SUB; a = 32'h0005; b = 32'h0003; start16 = 1'b1;
      repeat (2) @(negedge clk);
      start16 = 1'b0;
      cyc = 0;
      while (!d16_done && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      e = model(16, OP_MULU, 64'h1234, 64'h0100);
      vectors++;
      if (obs(16) !== e) begin
         miscompares++;
         $display("FAIL busy_ignore: got %h want %h", obs(16), e);
      end
      op = OP_SUB; a = 32'h0009; b = 32'h0020; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      e = model(16, OP_SUB, 64'h0009, 64'h0020);
      vectors++;
      if (d16_done !== 1'b1 || obs(16) !== e) begin
         miscompares++;
         $display("FAIL done_cycle_issue: done %b got %h want 1 %h", d16_done, obs(16), e);
      end
      @(negedge clk);
      vectors++;
      if (d16_done !== 1'b0 || obs(16) !== e) begin
         miscompares++;
         $display("FAIL done_single_pulse: done %b got %h want 0 %h", d16_done, obs(16), e);
      end
   endtask

   task automatic test_reset_mid();
      int   lat, busy_n, seen;
      exp_t e;
      @(negedge clk);
      op = OP_DIVU; a = 32'd100; b = 32'd7; start16 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start16 = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (obs(16) !== exp_t'(0) || d16_busy !== 1'b0 || d16_done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_abort: got %h busy %b done %b want 0", obs(16), d16_busy, d16_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (25) begin
         @(negedge clk);
         seen += int'(d16_done);
      end
      vectors++;
      if (seen !== 0) begin
         miscompares++;
         $display("FAIL reset_no_done: got %0d Done pulses want 0", seen);
      end
      issue(16, OP_SRA, 32'h8000, 32'd4, lat, busy_n);
      e = model(16, OP_SRA, 64'h8000, 64'd4);
      vectors++;
      if (obs(16) !== e || d16_res !== 16'hF800) begin
         miscompares++;
         $display("FAIL sra_after_reset: got %h want %h", obs(16), e);
      end
   endtask

   task automatic test_random(input int w, input int n);
      int          lat, busy_n;
      logic [3:0]  o;
      logic [31:0] av, bv;
      exp_t        e, held;
      for (int i = 0; i < n; i++) begin
         o  = 4'($urandom_range(0, 15));
         av = $urandom();
         bv = $urandom();
         if ($urandom_range(0, 7) == 0) bv = '0;
         else if ($urandom_range(0, 3) == 0) bv = 32'($urandom_range(1, 40));
         if (w == 16) begin av[31:16] = '0; bv[31:16] = '0; end
         issue(w, o, av, bv, lat, busy_n);
         e = model(w, o, 64'(av), 64'(bv));
         vectors++;
         if (obs(w) !== e) begin
            miscompares++;
            $display("FAIL rand_w%0d op=%0d a=%h b=%h: got %h want %h", w, o, av, bv, obs(w), e);
         end
         vectors++;
         if (lat !== exp_lat(w, o, 64'(bv)) || busy_n !== exp_lat(w, o, 64'(bv))) begin
            miscompares++;
            $display("FAIL rand_timing_w%0d op=%0d: lat %0d busy %0d want %0d", w, o, lat, busy_n, exp_lat(w, o, 64'(bv)));
         end
         a = $urandom();
         b = $urandom();
         @(negedge clk);
         held = obs(w);
         vectors++;
         if (done_w(w) !== 1'b0 || held !== e) begin
            miscompares++;
            $display("FAIL rand_hold_w%0d op=%0d: done %b got %h want 0 %h", w, o, done_w(w), held, e);
         end
      end
   endtask

   task automatic test_w32_mulu();
      int   lat, busy_n;
      exp_t e;
      issue(32, OP_MULU, 32'hFFFF_FFFF, 32'd2, lat, busy_n);
      e = model(32, OP_MULU, 64'hFFFF_FFFF, 64'd2);
      vectors++;
      if (obs(32) !== e || d32_res !== 32'hFFFF_FFFE || d32_hi !== 32'h0000_0001) begin
         miscompares++;
         $display("FAIL mulu_w32: got %h want %h", obs(32), e);
      end
      vectors++;
      if (lat !== 33 || busy_n !== 33) begin
         miscompares++;
         $display("FAIL mulu_w32_latency: lat %0d busy %0d want 33 33", lat, busy_n);
      end
   endtask

   initial begin
      test_reset();
      test_add_ovfl();
      test_mulu_divu();
      test_back_to_back();
      test_reset_mid();
      test_random(16, 150);
      test_w32_mulu();
      test_random(32, 40);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/merc_exec_unit.md
# merc_exec_unit

Parametrised execution unit for the MERC processor family. It generalises the 16-bit single-cycle ALU path to a WIDTH-bit unit. It adds iterative unsigned multiply and divide behind a Start/Busy/Done handshake and registers the comparison flags with each result. It sits between the operand registers (A/B) and the ALU_Out register, and the multicycle control FSM sequences it.

## Interface
Parameters:
- WIDTH, 16, datapath width; legal range 8–64, power of two.
- SHAMT_W, $clog2(WIDTH), number of B bits used as the shift amount.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  operation request; sampled only while Busy=0.
- Op  in  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 MULU, 9 DIVU; 10–15 reserved.
- A  in  WIDTH  operand A; captured when Start is accepted.
- B  in  WIDTH  operand B; captured when Start is accepted.
- Busy  out  1  operation in progress.
- Done  out  1  single-cycle pulse; the result outputs update in the same cycle.
- Result  out  WIDTH  primary result (MULU: low half of product; DIVU: quotient).
- ResultHi  out  WIDTH  MULU: high half of product; DIVU: remainder; otherwise 0.
- EQ, GR, LT  out  1 each  signed comparison of the captured A against the captured B.
- Zero  out  1  Result == 0.
- Ovfl  out  1  ADD/SUB: signed overflow. MULU: ResultHi != 0. Otherwise 0.
- DivByZero  out  1  DIVU issued with B == 0.

## Operation
- States: IDLE, ITER, FIN.
- IDLE, Start=1, Op ≤ 7 or reserved:
  - Compute the result; register all outputs at this edge (the edge that accepts Start).
  - Pulse Done; stay in IDLE.
  - Busy is never asserted for these ops.
- IDLE, Start=1, Op = MULU, or Op = DIVU with B ≠ 0:
  - Capture A and B; load the iteration counter with WIDTH; go to ITER; Busy=1.
- ITER:
  - Perform one shift-add (MULU) or one restoring shift-subtract (DIVU) step per cycle; decrement the counter.
  - When the counter reaches 1, go to FIN.
- FIN: register the outputs, pulse Done, Busy=0, return to IDLE.
- DIVU with B = 0: handled as a single-cycle op. Result = all ones, ResultHi = A, DivByZero=1, Ovfl=0.
- Reserved ops: Result=0, ResultHi=0, flags computed normally.
- Shifts use B[SHAMT_W-1:0]. SRA replicates A[WIDTH-1].
- ADD/SUB wrap modulo 2^WIDTH.
- Flags are computed from the operands captured at Start and update only when Done pulses.
- All outputs hold their values between Done pulses.
- Start while Busy=1 is ignored; the requester must hold or re-issue it.

## Timing
- Reset asserted:
  - State IDLE.
  - Busy, Done, Result, ResultHi, EQ, GR, LT, Zero, Ovfl, DivByZero all 0.
  - Counter cleared.
- Reset asserted mid-iteration aborts immediately; no Done pulse.
- Single-cycle ops: Start accepted at edge N. Done=1 and outputs valid from N through N+1.
- MULU/DIVU: Start accepted at edge N. Busy=1 from N to N+WIDTH+1. Done=1 with valid outputs after edge N+WIDTH+1. Latency is WIDTH+1 cycles; it is 17 for WIDTH=16.
- Back-to-back issue: Start may be high in the cycle Done is high, because Busy=0 then. It is accepted at the next edge.
- Done is never high for two consecutive cycles from a single Start.

## Structure
- Package merc_exec_pkg holds:
  - Op encoding localparams (OP_ADD … OP_DIVU).
  - State enum {IDLE, ITER, FIN}.
  - Op width constant (4).
- Sub-module merc_muldiv_iter holds the iterative datapath:
  - Registers: accumulator, multiplicand/divisor, and counter.
  - Inputs: load, step and mode.
  - Outputs: lo/hi results and a last-step flag.
- The parent holds the FSM, the combinational ALU/shifter, flag logic and output registers.

## Test plan
- WIDTH=16, ADD A=0x7FFF, B=0x0001 -> Done next cycle, Result=0x8000, Ovfl=1, GR=1, Zero=0, Busy never 1.
- WIDTH=16, MULU A=0x1234, B=0x0100 -> Busy for 17 cycles; Done with Result=0x3400, ResultHi=0x0012, Ovfl=1.
- WIDTH=16, DIVU A=100, B=7 -> after 17 cycles Result=14, ResultHi=2, DivByZero=0. Repeat with B=0 -> Done next cycle, Result=0xFFFF, ResultHi=100, DivByZero=1.
- Start pulsed with SUB while MULU is Busy -> ignored, MULU result unaffected. SUB issued in the Done cycle -> accepted, SUB Done exactly one cycle later.
- Reset driven low at cycle 5 of a DIVU -> all outputs 0 asynchronously; no Done. After reset release, SRA A=0x8000, B=4 -> Result=0xF800.
- WIDTH=32, MULU A=0xFFFFFFFF, B=2 -> Done after 33 cycles, Result=0xFFFFFFFE, ResultHi=0x00000001.
